// File: rtl/fib_seq_ctrl_if.sv
// Handshake bundle between a requester and the Fibonacci sequencing controller.
// The requester drives start/abort/n and watches the status and result lines.
interface fib_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int N_W   = 5
);
  logic             start;
  logic             abort;
  logic [N_W-1:0]   n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic [N_W-1:0]   idx;

  modport master (
    output start, abort, n,
    input  busy, done, result, ovf, idx
  );

  modport slave (
    input  start, abort, n,
    output busy, done, result, ovf, idx
  );
endinterface

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencing controller: clears the (a,b) register pair to (0,1),
// steps it exactly n times and then freezes, presenting F(n) on result with a
// sticky overflow flag. Optional macro FIB_SAT_EN saturates an overflowed
// result to all-ones instead of returning the wrapped low bits.
module fib_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int N_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  fib_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             a_ovf;
  logic             b_ovf;
  logic [N_W-1:0]   idx;
  logic [N_W-1:0]   n_lat;
  logic [WIDTH-1:0] result;
  logic             ovf;

  logic [WIDTH:0]   sum;
  logic             accept;
  logic             step;
  logic             finish;

  // The extra top bit of the sum is the adder carry-out used for overflow.
  assign sum = {1'b0, a} + {1'b0, b};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath strobes; abort overrides everything else.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (idx == n_lat) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end else begin
            step = 1'b1;
          end
        end
        DONE: begin
          if (bus.start) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register pair, step counter and the frozen result. The finishing edge
  // leaves a/b untouched so a late carry into b cannot taint F(n) held in a.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a      <= '0;
      b      <= WIDTH'(1);
      a_ovf  <= 1'b0;
      b_ovf  <= 1'b0;
      idx    <= '0;
      n_lat  <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else if (accept) begin
      n_lat <= bus.n;
      a     <= '0;
      b     <= WIDTH'(1);
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
      idx   <= '0;
    end else if (step) begin
      a     <= b;
      a_ovf <= b_ovf;
      b     <= sum[WIDTH-1:0];
      b_ovf <= a_ovf | b_ovf | sum[WIDTH];
      idx   <= idx + N_W'(1);
    end else if (finish) begin
`ifdef FIB_SAT_EN
      result <= a_ovf ? '1 : a;
`else
      result <= a;
`endif
      ovf <= a_ovf;
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = result;
  assign bus.ovf    = ovf;
  assign bus.idx    = idx;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: a table of boundary terms, randomized
// terms against an arithmetic Fibonacci model, and hand-written sequences for
// reset, restart, ignored start and abort behaviour.
module tb_fib_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int N_W   = 5;

  typedef struct {
    int n;
    int exp_result;
    int exp_ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fib_seq_ctrl_if #(.WIDTH(WIDTH), .N_W(N_W)) bus ();

  fib_seq_ctrl #(.WIDTH(WIDTH), .N_W(N_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Plain arithmetic Fibonacci, independent of any register-pair view.
  function automatic longint fib(input int k);
    longint x;
    longint y;
    longint t;
    x = 0;
    y = 1;
    for (int i = 0; i < k; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic int model_result(input int k);
    longint f;
    f = fib(k);
    if (f > 255) begin
`ifdef FIB_SAT_EN
      return 255;
`else
      return int'(f % 256);
`endif
    end
    return int'(f);
  endfunction

  function automatic int model_ovf(input int k);
    return (fib(k) > 255) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic ab, input int nn);
    bus.start = s;
    bus.abort = ab;
    bus.n     = N_W'(nn);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Start a run of term nn and wait for done; returns edges counted from the
  // accepting edge and the number of sampled cycles with busy high.
  task automatic runTerm(input int nn, input bit spurious,
                         output int edges, output int busy_cnt);
    applyStimulus(1'b1, 1'b0, nn);
    tick();
    edges    = 1;
    busy_cnt = 0;
    applyStimulus(1'b0, 1'b0, 0);
    while (!bus.done && edges < 200) begin
      if (bus.busy) busy_cnt++;
      if (spurious && $urandom_range(0, 3) == 0)
        applyStimulus(1'b1, 1'b0, int'($urandom_range(0, 31)));
      else
        applyStimulus(1'b0, 1'b0, 0);
      tick();
      edges++;
    end
    applyStimulus(1'b0, 1'b0, 0);
  endtask

  vec_t vecs[8];
  int   edges;
  int   busy_cnt;
  int   rn;

  initial begin
    checks   = 0;
    failures = 0;

    // Boundary table; expected terms written out from the Fibonacci series.
    vecs[0] = '{n: 0,  exp_result: 0,   exp_ovf: 0};
    vecs[1] = '{n: 1,  exp_result: 1,   exp_ovf: 0};
    vecs[2] = '{n: 2,  exp_result: 1,   exp_ovf: 0};
    vecs[3] = '{n: 10, exp_result: 55,  exp_ovf: 0};
    vecs[4] = '{n: 13, exp_result: 233, exp_ovf: 0};
`ifdef FIB_SAT_EN
    vecs[5] = '{n: 14, exp_result: 255, exp_ovf: 1};
    vecs[6] = '{n: 20, exp_result: 255, exp_ovf: 1};
    vecs[7] = '{n: 31, exp_result: 255, exp_ovf: 1};
`else
    vecs[5] = '{n: 14, exp_result: 121, exp_ovf: 1};
    vecs[6] = '{n: 20, exp_result: 109, exp_ovf: 1};
    vecs[7] = '{n: 31, exp_result: 221, exp_ovf: 1};
`endif

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 0);
    #12;
    checkOutput("reset_busy",   int'(bus.busy),   0);
    checkOutput("reset_done",   int'(bus.done),   0);
    checkOutput("reset_result", int'(bus.result), 0);
    checkOutput("reset_ovf",    int'(bus.ovf),    0);
    checkOutput("reset_idx",    int'(bus.idx),    0);
    rst = 1'b0;
    tick();

    // Boundary terms, latency, busy width and hold-while-done.
    for (int i = 0; i < 8; i++) begin
      runTerm(vecs[i].n, 1'b0, edges, busy_cnt);
      checkOutput($sformatf("tbl_done_n%0d", vecs[i].n),   int'(bus.done),   1);
      checkOutput($sformatf("tbl_edges_n%0d", vecs[i].n),  edges,            vecs[i].n + 2);
      checkOutput($sformatf("tbl_busy_n%0d", vecs[i].n),   busy_cnt,         vecs[i].n + 1);
      checkOutput($sformatf("tbl_result_n%0d", vecs[i].n), int'(bus.result), vecs[i].exp_result);
      checkOutput($sformatf("tbl_ovf_n%0d", vecs[i].n),    int'(bus.ovf),    vecs[i].exp_ovf);
      checkOutput($sformatf("tbl_idx_n%0d", vecs[i].n),    int'(bus.idx),    vecs[i].n);
      for (int h = 0; h < 3; h++) tick();
      checkOutput($sformatf("tbl_hold_done_n%0d", vecs[i].n),   int'(bus.done),   1);
      checkOutput($sformatf("tbl_hold_result_n%0d", vecs[i].n), int'(bus.result), vecs[i].exp_result);
    end

    // Randomized terms with stray start pulses during RUN.
    for (int r = 0; r < 20; r++) begin
      rn = int'($urandom_range(0, 31));
      runTerm(rn, 1'b1, edges, busy_cnt);
      checkOutput($sformatf("rnd_edges_n%0d", rn),  edges,            rn + 2);
      checkOutput($sformatf("rnd_result_n%0d", rn), int'(bus.result), model_result(rn));
      checkOutput($sformatf("rnd_ovf_n%0d", rn),    int'(bus.ovf),    model_ovf(rn));
    end

    // Reset in the middle of a run clears everything without a clock edge.
    runTerm(5, 1'b0, edges, busy_cnt);
    applyStimulus(1'b1, 1'b0, 10);
    tick();
    applyStimulus(1'b0, 1'b0, 0);
    for (int h = 0; h < 3; h++) tick();
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_busy",   int'(bus.busy),   0);
    checkOutput("midrst_done",   int'(bus.done),   0);
    checkOutput("midrst_result", int'(bus.result), 0);
    checkOutput("midrst_idx",    int'(bus.idx),    0);
    #2 rst = 1'b0;
    tick();
    runTerm(10, 1'b0, edges, busy_cnt);
    checkOutput("postrst_edges",  edges,            12);
    checkOutput("postrst_result", int'(bus.result), 55);
    checkOutput("postrst_ovf",    int'(bus.ovf),    0);

    // Start during RUN is ignored; start from DONE restarts immediately.
    applyStimulus(1'b1, 1'b0, 5);
    tick();
    applyStimulus(1'b0, 1'b0, 0);
    tick();
    applyStimulus(1'b1, 1'b0, 2);
    tick();
    applyStimulus(1'b0, 1'b0, 0);
    tick();
    tick();
    tick();
    checkOutput("ign_done_e6", int'(bus.done), 0);
    tick();
    checkOutput("ign_done_e7", int'(bus.done),   1);
    checkOutput("ign_result",  int'(bus.result), 5);
    applyStimulus(1'b1, 1'b0, 7);
    tick();
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("restart_busy", int'(bus.busy), 1);
    checkOutput("restart_done", int'(bus.done), 0);
    for (int h = 0; h < 7; h++) tick();
    checkOutput("restart_done_e8", int'(bus.done), 0);
    tick();
    checkOutput("restart_done_e9", int'(bus.done),   1);
    checkOutput("restart_result",  int'(bus.result), 13);

    // Abort at edge 4 of an n=12 run keeps the previous result.
    applyStimulus(1'b1, 1'b0, 12);
    tick();
    applyStimulus(1'b0, 1'b0, 0);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("abort_busy",   int'(bus.busy),   0);
    checkOutput("abort_done",   int'(bus.done),   0);
    checkOutput("abort_result", int'(bus.result), 13);
    tick();
    checkOutput("abort_idle_busy", int'(bus.busy), 0);

    // Start and abort together in IDLE: abort wins.
    applyStimulus(1'b1, 1'b1, 3);
    tick();
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("startabort_busy",   int'(bus.busy),   0);
    checkOutput("startabort_done",   int'(bus.done),   0);
    checkOutput("startabort_result", int'(bus.result), 13);

    // Abort from DONE drops done and keeps result/ovf.
    runTerm(20, 1'b0, edges, busy_cnt);
    applyStimulus(1'b0, 1'b1, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("abortdone_done",   int'(bus.done),   0);
    checkOutput("abortdone_result", int'(bus.result), model_result(20));
    checkOutput("abortdone_ovf",    int'(bus.ovf),    1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
